blake_round_sequencer: RTL
==========================

// Module: blake_round_sequencer
// PURPOSE
//  Iterative BLAKE-256 compression controller: owns the 16-word state v and
//  sequences 4 BLAKE_G_FUNCTION instances over 2*ROUNDS half-rounds.
//  - One half-round per clock, alternating column and diagonal steps.
//  - Applies the sigma message schedule and constant XOR feeds each cycle.
//  - Loads from the midstate/block input; emits the chained hash h'.
//  - Sits between the nonce/work loader and the target comparator.
// PARAMETERS
//  ROUNDS  8  rounds per compression; legal 1..14 (8 Blakecoin, 14 BLAKE-256)
// PORTS
//  clk       in   1    single clock; all state updates on rising edge
//  rst_n     in   1    synchronous active-low reset
//  in_valid  in   1    h_in/m_in/t_in valid
//  in_ready  out  1    combinational: 1 iff state==IDLE
//  h_in      in   256  chaining value; word i = bits[32i+31:32i]
//  m_in      in   512  message block, 16 big-endian-decoded words, same packing
//  t_in      in   64   bit counter; t0 = [31:0], t1 = [63:32]
//  out_valid out  1    registered; h_out valid, held until out_ready
//  out_ready in   1    consumer accepts h_out
//  h_out     out  256  h'_i = h_i ^ v_i ^ v_(i+8); salt fixed to 0
//  busy      out  1    registered; 1 in RUN or FINAL
//  round_idx out  4    registered; current round 0..ROUNDS-1 (0 when idle)
// BEHAVIOUR
//  Reset (rst_n low at an edge, any state, including mid-RUN):
//  - state=IDLE; out_valid=0, h_out=0, busy=0, round_idx=0, half=0.
//  - v is cleared; any job in flight is discarded with no output.
//  States:
//  - IDLE: on in_valid & in_ready, latch h_in/m_in/t_in and initialise v:
//    v0..7=h; v8..11=c0..c3; v12=c4^t0; v13=c5^t0; v14=c6^t1; v15=c7^t1.
//    Then go to RUN with round_idx=0, half=0, busy=1.
//  - RUN, half=0 (column step):
//    G0(v0,v4,v8,v12) G1(v1,v5,v9,v13) G2(v2,v6,v10,v14) G3(v3,v7,v11,v15).
//  - RUN, half=1 (diagonal step):
//    G4(v0,v5,v10,v15) G5(v1,v6,v11,v12) G6(v2,v7,v8,v13) G7(v3,v4,v9,v14).
//  - G message feeds: s = sigma[round_idx mod 10]; Gk uses
//    msg_i = m[s[2k]] ^ c[s[2k+1]] and msg_ip = m[s[2k+1]] ^ c[s[2k]].
//    c0..c15 are the standard BLAKE-256 constants (pi digits).
//  - Each RUN edge writes the four G outputs back to v and toggles half.
//    round_idx increments when half goes 1->0.
//    After the diagonal step of round ROUNDS-1, go to FINAL.
//  - FINAL (1 cycle): h_out <= h ^ v[0..7] ^ v[8..15]; out_valid<=1;
//    busy<=0; round_idx<=0; go to DONE.
//  - DONE: hold h_out/out_valid stable. On out_ready, out_valid<=0 and go
//    to IDLE; in_ready rises the cycle after.
//  Latency and throughput:
//  - Accept edge k gives out_valid high after edge k+2*ROUNDS+1
//    (17 edges for ROUNDS=8, 29 for 14).
//  - Throughput: one job per 2*ROUNDS+3 cycles with out_ready tied high.
//  Boundary conditions:
//  - in_valid is ignored outside IDLE; latched inputs are stable during the
//    job, so inputs may change freely after acceptance.
//  - Same-cycle out_ready and a new in_valid: no overlap; the new job is
//    accepted no earlier than the cycle after DONE->IDLE.
//  - sigma index wraps: rounds 10..13 reuse sigma[0..3].
//  - All additions are mod 2^32 inside G; no carries leave a word.
// TESTING
//  - ROUNDS=14; h=IV, m0=0x80000000, m13=1, others 0, t=0
//    -> h_out words 0..7 = 716f6e86 3f744b9a c22c97ec 7b76ea5f
//       5908bc5b 2f67c615 10bfc475 1384ea7a.
//  - ROUNDS=14; h=IV, m0=0x00800000, m13=1, m15=8, t=8
//    -> h_out = 0ce8d4ef 4dd7cd8d 62dfded9 d4edb0a7 74ae6a41 929a74da
//       23109e8f 11139c87.
//  - ROUNDS=8; 1000 random h/m/t -> h_out bit-exact vs 8-round C model.
//    Latency is exactly 17 edges and round_idx steps 0..7 twice each.
//  - Backpressure: hold out_ready=0 for 20 cycles while toggling in_valid
//    and inputs -> h_out stable, in_ready=0, no second job started.
//  - rst_n low for 1 cycle at round 3 -> all outputs 0 next cycle.
//    A new job accepted afterwards gives correct h_out, with no residue.
//  - Back-to-back jobs with out_ready=1 -> accept every 2*ROUNDS+3 cycles;
//    in_valid held high across DONE causes no double-accept of the same job.

Source files
------------

// File: rtl/blake_round_sequencer.sv
// Iterative BLAKE-256 compression core: one half-round (4 G functions) per clock,
// alternating column and diagonal steps, followed by the h' finalisation.
module blake_round_sequencer #(
   parameter int ROUNDS = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [255:0] h_in,
   input  logic [511:0] m_in,
   input  logic [63:0]  t_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [255:0] h_out,
   output logic         busy,
   output logic [3:0]   round_idx
);
   typedef enum logic [1:0] {IDLE, RUN, FINAL, DONE} state_t;

   localparam logic [511:0] C_WORDS = {
      32'hB5470917, 32'h3F84D5B5, 32'hC97C50DD, 32'hC0AC29B7,
      32'h34E90C6C, 32'hBE5466CF, 32'h38D01377, 32'h452821E6,
      32'hEC4E6C89, 32'h082EFA98, 32'h299F31D0, 32'hA4093822,
      32'h03707344, 32'h13198A2E, 32'h85A308D3, 32'h243F6A88};

   // Permutation rows packed with element i in nibble i.
   function automatic logic [63:0] sigma_row(input logic [3:0] r);
      case (r)
         4'd1:    sigma_row = 64'h357B20C16DF984AE;
         4'd2:    sigma_row = 64'h491763EADF250C8B;
         4'd3:    sigma_row = 64'h8F04A562EBCD1397;
         4'd4:    sigma_row = 64'hD386CB1EFA427509;
         4'd5:    sigma_row = 64'h91EF57D438B0A6C2;
         4'd6:    sigma_row = 64'hB8293670A4DEF15C;
         4'd7:    sigma_row = 64'hA2684F05931CE7BD;
         4'd8:    sigma_row = 64'h5A417D2C803B9EF6;
         4'd9:    sigma_row = 64'h0DC3E9BF5167482A;
         default: sigma_row = 64'hFEDCBA9876543210;
      endcase
   endfunction

   function automatic logic [127:0] g_func(input logic [31:0] a_i, b_i, c_i, d_i, mi, mip);
      logic [31:0] a, b, c, d;
      a = a_i + b_i + mi;
      d = d_i ^ a;  d = {d[15:0], d[31:16]};
      c = c_i + d;
      b = b_i ^ c;  b = {b[11:0], b[31:12]};
      a = a + b + mip;
      d = d ^ a;    d = {d[7:0], d[31:8]};
      c = c + d;
      b = b ^ c;    b = {b[6:0], b[31:7]};
      g_func = {a, b, c, d};
   endfunction

   state_t         state_q, state_d;
   logic [31:0]    v_q [16];
   logic [31:0]    v_d [16];
   logic [255:0]   h_q, h_d, h_out_q, h_out_d;
   logic [511:0]   m_q, m_d;
   logic           half_q, half_d, out_valid_q, out_valid_d, busy_q, busy_d;
   logic [3:0]     round_q, round_d;

   logic [3:0]     sig_sel;
   logic [63:0]    sig;
   logic [511:0]   g_flat;

   assign sig_sel = (round_q >= 4'd10) ? round_q - 4'd10 : round_q;
   assign sig     = sigma_row(sig_sel);

   for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      localparam int BD = 4 + ((gi + 1) % 4);
      localparam int CD = 8 + ((gi + 2) % 4);
      localparam int DD = 12 + ((gi + 3) % 4);
      logic [3:0]  s_even, s_odd;
      logic [31:0] b_in, c_in, d_in, msg_i, msg_ip;
      assign s_even = half_q ? sig[4*(2*gi+8) +: 4] : sig[4*(2*gi) +: 4];
      assign s_odd  = half_q ? sig[4*(2*gi+9) +: 4] : sig[4*(2*gi+1) +: 4];
      assign msg_i  = m_q[{s_even, 5'd0} +: 32] ^ C_WORDS[{s_odd, 5'd0} +: 32];
      assign msg_ip = m_q[{s_odd, 5'd0} +: 32] ^ C_WORDS[{s_even, 5'd0} +: 32];
      assign b_in   = half_q ? v_q[BD] : v_q[4+gi];
      assign c_in   = half_q ? v_q[CD] : v_q[8+gi];
      assign d_in   = half_q ? v_q[DD] : v_q[12+gi];
      assign g_flat[128*gi +: 128] = g_func(v_q[gi], b_in, c_in, d_in, msg_i, msg_ip);
   end

   always_comb begin
      state_d     = state_q;
      v_d         = v_q;
      h_d         = h_q;
      m_d         = m_q;
      half_d      = half_q;
      round_d     = round_q;
      out_valid_d = out_valid_q;
      h_out_d     = h_out_q;
      busy_d      = busy_q;
      case (state_q)
         IDLE: if (in_valid) begin
            h_d = h_in;
            m_d = m_in;
            for (int i = 0; i < 8; i++) v_d[i] = h_in[32*i +: 32];
            for (int i = 0; i < 4; i++) v_d[8+i] = C_WORDS[32*i +: 32];
            v_d[12] = C_WORDS[4*32 +: 32] ^ t_in[31:0];
            v_d[13] = C_WORDS[5*32 +: 32] ^ t_in[31:0];
            v_d[14] = C_WORDS[6*32 +: 32] ^ t_in[63:32];
            v_d[15] = C_WORDS[7*32 +: 32] ^ t_in[63:32];
            half_d  = 1'b0;
            round_d = 4'd0;
            busy_d  = 1'b1;
            state_d = RUN;
         end
         RUN: begin
            for (int j = 0; j < 4; j++) begin
               v_d[j] = g_flat[128*j+96 +: 32];
               if (half_q) begin
                  v_d[4 + ((j + 1) % 4)]  = g_flat[128*j+64 +: 32];
                  v_d[8 + ((j + 2) % 4)]  = g_flat[128*j+32 +: 32];
                  v_d[12 + ((j + 3) % 4)] = g_flat[128*j +: 32];
               end else begin
                  v_d[4+j]  = g_flat[128*j+64 +: 32];
                  v_d[8+j]  = g_flat[128*j+32 +: 32];
                  v_d[12+j] = g_flat[128*j +: 32];
               end
            end
            half_d = ~half_q;
            if (half_q) begin
               if (round_q == 4'(ROUNDS - 1)) state_d = FINAL;
               else                           round_d = round_q + 4'd1;
            end
         end
         FINAL: begin
            for (int i = 0; i < 8; i++)
               h_out_d[32*i +: 32] = h_q[32*i +: 32] ^ v_q[i] ^ v_q[i+8];
            out_valid_d = 1'b1;
            busy_d      = 1'b0;
            round_d     = 4'd0;
            state_d     = DONE;
         end
         default: if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         for (int i = 0; i < 16; i++) v_q[i] <= '0;
         h_q         <= '0;
         m_q         <= '0;
         half_q      <= 1'b0;
         round_q     <= 4'd0;
         out_valid_q <= 1'b0;
         h_out_q     <= '0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         v_q         <= v_d;
         h_q         <= h_d;
         m_q         <= m_d;
         half_q      <= half_d;
         round_q     <= round_d;
         out_valid_q <= out_valid_d;
         h_out_q     <= h_out_d;
         busy_q      <= busy_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = out_valid_q;
   assign h_out     = h_out_q;
   assign busy      = busy_q;
   assign round_idx = round_q;
endmodule
